// File: rtl/data_mem_ctrl.sv
// Load/store sequencer for the big-endian, word-wide DataMemory.
// Issues one-cycle strobes, does read-modify-write for sub-word stores and rejects bad accesses.
module data_mem_ctrl #(
    parameter int MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_reg, state_next;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic        write_reg;
    logic [1:0]  off_reg;
    logic [15:0] wdata_reg;

    logic        req_ready_reg, req_ready_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [31:0] resp_data_reg, resp_data_next;
    logic        resp_fault_reg, resp_fault_next;
    logic [31:0] mem_address_reg, mem_address_next;
    logic [31:0] mem_write_data_reg, mem_write_data_next;
    logic        mem_read_reg, mem_read_next;
    logic        mem_write_reg, mem_write_next;

    logic        accept;
    logic        req_fault;
    logic [7:0]  lane_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    assign accept = req_valid && req_ready_reg;

    always_comb begin
        req_fault = 1'b0;
        case (req_size)
            SZ_BYTE: req_fault = 1'b0;
            SZ_HALF: req_fault = req_address[0];
            SZ_WORD: req_fault = |req_address[1:0];
            default: req_fault = 1'b1;
        endcase
        if (req_address >= 32'(MEM_BYTES)) begin
            req_fault = 1'b1;
        end
    end

    // Lane k sits at bits [31-8k -: 8]; half-word lanes pair as (0,1) and (2,3).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] lane_new;

            assign lane_bytes[gi] = mem_data[31-8*gi -: 8];
            assign lane_hit = ((size_reg == SZ_BYTE) && (off_reg == LANE)) ||
                              ((size_reg == SZ_HALF) && (off_reg[1] == LANE[1]));
            assign lane_new = ((size_reg == SZ_HALF) && !LANE[0]) ? wdata_reg[15:8]
                                                                 : wdata_reg[7:0];
            assign merged_word[31-8*gi -: 8] = lane_hit ? lane_new : lane_bytes[gi];
        end
    endgenerate

    always_comb begin
        sel_byte = lane_bytes[off_reg];
        sel_half = off_reg[1] ? mem_data[15:0] : mem_data[31:16];
        case (size_reg)
            SZ_BYTE: load_value = unsigned_reg ? {24'd0, sel_byte}
                                               : {{24{sel_byte[7]}}, sel_byte};
            SZ_HALF: load_value = unsigned_reg ? {16'd0, sel_half}
                                               : {{16{sel_half[15]}}, sel_half};
            default: load_value = mem_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            req_ready_reg      <= 1'b1;
            resp_valid_reg     <= 1'b0;
            resp_data_reg      <= 32'd0;
            resp_fault_reg     <= 1'b0;
            mem_address_reg    <= 32'd0;
            mem_write_data_reg <= 32'd0;
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
        end else begin
            state_reg          <= state_next;
            req_ready_reg      <= req_ready_next;
            resp_valid_reg     <= resp_valid_next;
            resp_data_reg      <= resp_data_next;
            resp_fault_reg     <= resp_fault_next;
            mem_address_reg    <= mem_address_next;
            mem_write_data_reg <= mem_write_data_next;
            mem_read_reg       <= mem_read_next;
            mem_write_reg      <= mem_write_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_reg     <= SZ_BYTE;
            unsigned_reg <= 1'b0;
            write_reg    <= 1'b0;
            off_reg      <= 2'd0;
            wdata_reg    <= 16'd0;
        end else if (accept) begin
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            write_reg    <= req_write;
            off_reg      <= req_address[1:0];
            wdata_reg    <= req_wdata[15:0];
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_next          = state_reg;
        req_ready_next      = 1'b0;
        resp_valid_next     = 1'b0;
        resp_data_next      = 32'd0;
        resp_fault_next     = 1'b0;
        mem_read_next       = 1'b0;
        mem_write_next      = 1'b0;
        mem_address_next    = mem_address_reg;
        mem_write_data_next = mem_write_data_reg;
        case (state_reg)
            IDLE: begin
                req_ready_next      = 1'b1;
                mem_address_next    = 32'd0;
                mem_write_data_next = 32'd0;
                if (accept) begin
                    req_ready_next = 1'b0;
                    if (req_fault) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_fault_next = 1'b1;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_next          = WR;
                        mem_write_next      = 1'b1;
                        mem_address_next    = {req_address[31:2], 2'b00};
                        mem_write_data_next = req_wdata;
                    end else begin
                        state_next       = RD;
                        mem_read_next    = 1'b1;
                        mem_address_next = {req_address[31:2], 2'b00};
                    end
                end
            end
            RD: begin
                state_next = CAP;
            end
            CAP: begin
                if (write_reg) begin
                    state_next          = WR;
                    mem_write_next      = 1'b1;
                    mem_write_data_next = merged_word;
                end else begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_data_next  = load_value;
                end
            end
            WR: begin
                state_next      = RESP;
                resp_valid_next = 1'b1;
            end
            RESP: begin
                state_next          = IDLE;
                req_ready_next      = 1'b1;
                mem_address_next    = 32'd0;
                mem_write_data_next = 32'd0;
            end
            default: begin
                state_next          = IDLE;
                req_ready_next      = 1'b1;
                mem_address_next    = 32'd0;
                mem_write_data_next = 32'd0;
            end
        endcase
    end

    assign req_ready      = req_ready_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_data      = resp_data_reg;
    assign resp_fault     = resp_fault_reg;
    assign mem_address    = mem_address_reg;
    assign mem_write_data = mem_write_data_reg;
    assign mem_read       = mem_read_reg;
    assign mem_write      = mem_write_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a strobe-driven big-endian DataMemory model.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;

    int n_checks = 0;
    int n_errors = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int resp_cnt = 0;

    logic [7:0] mem [2048];

    data_mem_ctrl #(.MEM_BYTES(2048)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_address    (req_address),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_fault     (resp_fault),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_data       (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory model: acts on strobe rising edges, always moves four bytes.
    always @(posedge mem_read) begin
        #1;
        rd_pulses++;
        mem_data = {mem[{mem_address[10:2], 2'd0}], mem[{mem_address[10:2], 2'd1}],
                    mem[{mem_address[10:2], 2'd2}], mem[{mem_address[10:2], 2'd3}]};
    end

    always @(posedge mem_write) begin
        #1;
        wr_pulses++;
        mem[{mem_address[10:2], 2'd0}] = mem_write_data[31:24];
        mem[{mem_address[10:2], 2'd1}] = mem_write_data[23:16];
        mem[{mem_address[10:2], 2'd2}] = mem_write_data[15:8];
        mem[{mem_address[10:2], 2'd3}] = mem_write_data[7:0];
    end

    always @(posedge clk) if (resp_valid) resp_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] v);
        mem[a] = v[31:24]; mem[a+1] = v[23:16]; mem[a+2] = v[15:8]; mem[a+3] = v[7:0];
    endtask

    function automatic logic [31:0] get_word(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_address = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_address = 32'd0; req_wdata = 32'd0;
    endtask

    // exp_rd / exp_wr / exp_resp are cycle numbers after acceptance; 0 = must not occur.
    task automatic run_access(input string tag, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                              input int exp_rd, input int exp_wr, input int exp_resp,
                              input logic [31:0] exp_data, input logic exp_fault,
                              input logic [31:0] exp_wdata);
        int rd_cyc = 0, wr_cyc = 0, resp_cyc = 0, rd_n = 0, wr_n = 0, rdy_n = 0;
        logic [31:0] got_data = 32'd0, got_wdata = 32'd0, got_addr = 32'd0;
        logic got_fault = 1'b0;
        @(negedge clk);
        check($sformatf("%s.ready_in", tag), 32'(req_ready), 32'd1);
        drive_req(wr, sz, uns, addr, wd);
        for (int c = 1; c <= 8 && resp_cyc == 0; c++) begin
            @(negedge clk);
            if (mem_read) begin rd_n++; rd_cyc = c; got_addr = mem_address; end
            if (mem_write) begin wr_n++; wr_cyc = c; got_wdata = mem_write_data; got_addr = mem_address; end
            if (req_ready) rdy_n++;
            if (resp_valid) begin resp_cyc = c; got_data = resp_data; got_fault = resp_fault; end
        end
        $display("txn %s addr=%h rd@%0d wr@%0d resp@%0d data=%h fault=%b",
                 tag, addr, rd_cyc, wr_cyc, resp_cyc, got_data, got_fault);
        check($sformatf("%s.rd_cyc", tag), 32'(rd_cyc), 32'(exp_rd));
        check($sformatf("%s.rd_n", tag), 32'(rd_n), (exp_rd != 0) ? 32'd1 : 32'd0);
        check($sformatf("%s.wr_cyc", tag), 32'(wr_cyc), 32'(exp_wr));
        check($sformatf("%s.wr_n", tag), 32'(wr_n), (exp_wr != 0) ? 32'd1 : 32'd0);
        check($sformatf("%s.resp_cyc", tag), 32'(resp_cyc), 32'(exp_resp));
        check($sformatf("%s.busy", tag), 32'(rdy_n), 32'd0);
        check($sformatf("%s.data", tag), got_data, exp_data);
        check($sformatf("%s.fault", tag), 32'(got_fault), 32'(exp_fault));
        if (exp_wr != 0) check($sformatf("%s.wdata", tag), got_wdata, exp_wdata);
        if (exp_rd != 0 || exp_wr != 0)
            check($sformatf("%s.addr", tag), got_addr, {addr[31:2], 2'b00});
        @(negedge clk);
        check($sformatf("%s.ready_after", tag), 32'(req_ready), 32'd1);
        check($sformatf("%s.resp_1cyc", tag), 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_snap, rd_snap, resp_snap;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        set_word(32'h10, 32'h8899AABB);
        set_word(32'h14, 32'h01234567);
        set_word(32'h7FC, 32'hCAFEF00D);
        mem_data = 32'd0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_address = 32'd0; req_wdata = 32'd0;
        #3;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_data", resp_data, 32'd0);
        check("rst.resp_fault", 32'(resp_fault), 32'd0);
        check("rst.strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst.mem_address", mem_address, 32'd0);
        check("rst.mem_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Loads from 0x10 = 88 99 AA BB
        run_access("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 0, 3, 32'h8899AABB, 1'b0, 32'h0);
        run_access("lb11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1, 0, 3, 32'hFFFFFF99, 1'b0, 32'h0);
        run_access("lbu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1, 0, 3, 32'h00000099, 1'b0, 32'h0);
        run_access("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1, 0, 3, 32'hFFFFAABB, 1'b0, 32'h0);
        run_access("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1, 0, 3, 32'h0000AABB, 1'b0, 32'h0);
        run_access("lh10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1, 0, 3, 32'hFFFF8899, 1'b0, 32'h0);
        run_access("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 0, 3, 32'h000000BB, 1'b0, 32'h0);
        run_access("lb10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1, 0, 3, 32'hFFFFFF88, 1'b0, 32'h0);
        run_access("lw_unsigned_ignored", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1, 0, 3, 32'h8899AABB, 1'b0, 32'h0);

        // Sub-word stores via read-modify-write
        run_access("sb13",  1'b1, 2'b00, 1'b0, 32'h13, 32'h123456CC, 1, 3, 4, 32'h0, 1'b0, 32'h8899AACC);
        run_access("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 0, 3, 32'h8899AACC, 1'b0, 32'h0);
        run_access("sh10",  1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF1234, 1, 3, 4, 32'h0, 1'b0, 32'h1234AACC);
        run_access("lw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 0, 3, 32'h1234AACC, 1'b0, 32'h0);

        // Word store
        run_access("sw20",  1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 0, 1, 2, 32'h0, 1'b0, 32'hDEADBEEF);
        run_access("lw20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 0, 3, 32'hDEADBEEF, 1'b0, 32'h0);

        // Top-of-memory boundary
        run_access("lw7fc", 1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 1, 0, 3, 32'hCAFEF00D, 1'b0, 32'h0);
        run_access("lbu7ff",1'b0, 2'b00, 1'b1, 32'h7FF, 32'h0, 1, 0, 3, 32'h0000000D, 1'b0, 32'h0);
        run_access("lb7fe", 1'b0, 2'b00, 1'b0, 32'h7FE, 32'h0, 1, 0, 3, 32'hFFFFFFF0, 1'b0, 32'h0);

        // Faults: no strobes, response in C1
        wr_snap = wr_pulses; rd_snap = rd_pulses;
        run_access("f_lh11",  1'b0, 2'b01, 1'b0, 32'h11,  32'h0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        run_access("f_lw22",  1'b0, 2'b10, 1'b0, 32'h22,  32'h0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        run_access("f_lw800", 1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        run_access("f_size3", 1'b0, 2'b11, 1'b0, 32'h10,  32'h0, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        run_access("f_sw22",  1'b1, 2'b10, 1'b0, 32'h22,  32'h55555555, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        run_access("f_sb800", 1'b1, 2'b00, 1'b0, 32'h800, 32'h55, 0, 0, 1, 32'h0, 1'b1, 32'h0);
        check("fault.no_wr", 32'(wr_pulses), 32'(wr_snap));
        check("fault.no_rd", 32'(rd_pulses), 32'(rd_snap));
        check("fault.mem10", get_word(32'h10), 32'h1234AACC);

        // Reset during C2 of a half store
        @(negedge clk);
        wr_snap = wr_pulses; resp_snap = resp_cnt;
        drive_req(1'b1, 2'b01, 1'b0, 32'h14, 32'h0000BEEF);
        @(negedge clk);
        check("rstC2.rd_c1", 32'(mem_read), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstC2.rd", 32'(mem_read), 32'd0);
        check("rstC2.wr", 32'(mem_write), 32'd0);
        check("rstC2.ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        $display("txn rstC2 sh 0x14 wr_pulses=%0d resp=%0d mem14=%h",
                 wr_pulses - wr_snap, resp_cnt - resp_snap, get_word(32'h14));
        check("rstC2.no_wr", 32'(wr_pulses), 32'(wr_snap));
        check("rstC2.no_resp", 32'(resp_cnt), 32'(resp_snap));
        check("rstC2.ready_after", 32'(req_ready), 32'd1);
        check("rstC2.mem14", get_word(32'h14), 32'h01234567);

        // Reset during C1 of a load: strobe must drop asynchronously
        resp_snap = resp_cnt;
        drive_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        #2 rst = 1'b1;
        #1;
        $display("txn rstC1 lw 0x14 mem_read=%b mem_address=%h", mem_read, mem_address);
        check("rstC1.rd_drop", 32'(mem_read), 32'd0);
        check("rstC1.addr", mem_address, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rstC1.no_resp", 32'(resp_cnt), 32'(resp_snap));
        run_access("lw14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1, 0, 3, 32'h01234567, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
